// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed Booth multiply / restoring divide driving HI/LO write-back
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_we,
    output logic             lo_we
);
    typedef enum logic [2:0] {IDLE, MULT_RUN, DIV_RUN, FIX_SIGN, DONE, DZ} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_a, acc_q, m, abs_a, abs_b;
    logic qm1, is_div, sign_q, sign_r, last, div_ge;
    logic [WIDTH:0] booth_sum, div_shift, div_trial;
    assign last = cnt == CNT_W'(WIDTH - 1);
    assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;
    // One extra bit keeps A-M exact when M is the most negative value
    assign booth_sum = {acc_q[0], qm1} == 2'b01 ? {acc_a[WIDTH-1], acc_a} + {m[WIDTH-1], m} :
                       {acc_q[0], qm1} == 2'b10 ? {acc_a[WIDTH-1], acc_a} - {m[WIDTH-1], m} :
                                                  {acc_a[WIDTH-1], acc_a};
    assign div_shift = {acc_a, acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, m};
    assign div_ge = div_shift >= {1'b0, m};
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:              state_nx = mult_start ? MULT_RUN : !div_start ? IDLE :
                                          op_b == '0 ? DZ : DIV_RUN;
            MULT_RUN, DIV_RUN: state_nx = last ? FIX_SIGN : state;
            FIX_SIGN:          state_nx = DONE;
            default:           state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_we    <= 1'b0;
            lo_we    <= 1'b0;
        end else begin
            state    <= state_nx;
            busy     <= state_nx != IDLE;
            done     <= state_nx == DONE;
            div_zero <= state_nx == DZ;
            hi_we    <= state_nx == DONE;
            lo_we    <= state_nx == DONE;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            acc_a  <= '0;
            acc_q  <= '0;
            m      <= '0;
            qm1    <= 1'b0;
            is_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                IDLE: if (mult_start || div_start) begin
                    cnt    <= '0;
                    acc_a  <= '0;
                    qm1    <= 1'b0;
                    is_div <= !mult_start;
                    acc_q  <= mult_start ? op_b : abs_a;
                    m      <= mult_start ? op_a : abs_b;
                    sign_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                    sign_r <= op_a[WIDTH-1];
                end
                MULT_RUN: begin
                    acc_a <= booth_sum[WIDTH:1];
                    acc_q <= {booth_sum[0], acc_q[WIDTH-1:1]};
                    qm1   <= acc_q[0];
                    cnt   <= cnt + CNT_W'(1);
                end
                DIV_RUN: begin
                    acc_a <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_q <= {acc_q[WIDTH-2:0], div_ge};
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX_SIGN: begin
                    hi_out <= is_div && sign_r ? -acc_a : acc_a;
                    lo_out <= is_div && sign_q ? -acc_q : acc_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vector table plus start-hazard and mid-operation reset sequences
module tb_muldiv_sequencer;
    logic clk = 1'b0, reset = 1'b1, mult_start = 1'b0, div_start = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic busy, done, div_zero, hi_we, lo_we;
    logic [31:0] hi_out, lo_out;
    int checks = 0, errors = 0;
    typedef struct {
        logic ms;
        logic ds;
        logic [31:0] a, b, hi, lo;
        logic dz;
    } vec_t;
    vec_t vecs[13];
    always #5 clk = ~clk;
    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .mult_start(mult_start), .div_start(div_start),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
        .hi_out(hi_out), .lo_out(lo_out), .hi_we(hi_we), .lo_we(lo_we)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask
    task automatic launch(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mult_start = ms;
        div_start = ds;
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start = 1'b0;
    endtask
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        launch(v.ms, v.ds, v.a, v.b);
        check($sformatf("busy_c1[%0d]", idx), 32'(busy), 32'd1);
        n = 1;
        while (!(done || div_zero) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("latency[%0d]", idx), n, v.dz ? 32'd1 : 32'd34);
        check($sformatf("flags[%0d]", idx), 32'({done, div_zero, hi_we, lo_we}),
              32'({!v.dz, v.dz, !v.dz, !v.dz}));
        check($sformatf("hi[%0d]", idx), hi_out, v.hi);
        check($sformatf("lo[%0d]", idx), lo_out, v.lo);
        @(posedge clk);
        #1;
        check($sformatf("after[%0d]", idx), 32'({busy, done, div_zero, hi_we, lo_we}), 32'd0);
    endtask
    initial begin
        int n, cnt_dz, cnt_done;
        vecs[0]  = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'h00000692, 32'h00000020, 32'h00000012, 32'h00000034, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h00000055, 32'h00000000, 32'h00000012, 32'h00000034, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0};
        #2 reset = 1'b0;
        #1;
        check("reset_flags", 32'({busy, done, div_zero, hi_we, lo_we}), 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);
        // divide start injected at cycle 10 of a multiply must be dropped
        launch(1'b1, 1'b0, 32'h00000009, 32'hFFFFFFFC);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        div_start = 1'b1;
        op_b = 32'h0;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        n = 11;
        cnt_dz = div_zero ? 1 : 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (div_zero) cnt_dz++;
        end
        check("hazard_latency", n, 32'd34);
        check("hazard_hi", hi_out, 32'hFFFFFFFF);
        check("hazard_lo", lo_out, 32'hFFFFFFDC);
        cnt_done = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) cnt_done++;
            if (div_zero) cnt_dz++;
        end
        check("hazard_extra_done", cnt_done, 32'd0);
        check("hazard_dz", cnt_dz, 32'd0);
        // reset during a divide aborts at once and clears every output
        launch(1'b0, 1'b1, 32'h00000064, 32'h00000007);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("midreset_flags", 32'({busy, done, div_zero, hi_we, lo_we}), 32'd0);
        check("midreset_hi", hi_out, 32'd0);
        check("midreset_lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cnt_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || hi_we || lo_we) cnt_done++;
        end
        check("midreset_no_done", cnt_done, 32'd0);
        check("midreset_hold_lo", lo_out, 32'd0);
        run_vec('{1'b1, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0}, 13);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
